hazard_stall_controller: RTL

- Parametrised successor to the pipeline's single-cycle load-use hazard logic.
- Detects load-use hazards between ID/EX and IF/ID and holds a stall for a configurable number of cycles, for multi-cycle data memory.
- Also overlays a full-pipeline freeze while data memory is busy, generates branch flushes, and keeps a saturating stall-cycle performance counter.
- Sits beside the ID stage and drives the PC, IF/ID and control-mux enables.

---
 rtl/hazard_stall_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Load-use hazard / stall controller beside the ID stage.
// Detects load-use hazards between ID/EX and IF/ID and stalls the front end
// for a configurable number of bubbles (multi-cycle data memory), overlays a
// whole-pipeline freeze while data memory is busy, flushes on taken branches,
// and keeps a saturating count of cycles in which the PC was held.
// Outputs are combinational from state and inputs so the enables act in the
// same cycle the hazard, busy or branch condition is seen.
module hazard_stall_controller #(
    parameter int REG_ADDR_W        = 5,
    parameter int ZERO_REG          = 31,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] IDEX_RegisterRd,
    input  logic [REG_ADDR_W-1:0] IFID_RegisterRn,
    input  logic [REG_ADDR_W-1:0] IFID_RegisterRm,
    input  logic                  IFID_UsesRm,
    input  logic                  EXMEM_BranchTaken,
    input  logic                  DMem_Busy,
    output logic                  PCWire,
    output logic                  IFID_Write,
    output logic                  ControlWire,
    output logic                  IFID_Flush,
    output logic                  IDEX_Flush,
    output logic                  Pipe_Freeze,
    output logic [PERF_W-1:0]     StallCount
);

    localparam int REM_W = $clog2(16);
    localparam logic [REM_W-1:0]      REM_INIT  = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);
    localparam logic [PERF_W-1:0]     CNT_MAX   = {PERF_W{1'b1}};

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    state_t             state_r;
    logic [REM_W-1:0]   rem_r;
    logic [PERF_W-1:0]  stall_count_r;
    logic               hz_s;

    // Load-use hazard: the load's destination is read by the IF/ID instruction.
    always_comb begin
        hz_s = IDEX_MemRead
             & (IDEX_RegisterRd != ZERO_ADDR)
             & ((IDEX_RegisterRd == IFID_RegisterRn)
                | (IFID_UsesRm & (IDEX_RegisterRd == IFID_RegisterRm)));
    end

    // Enable/flush outputs by priority: reset, branch, memory busy, stall, normal.
    always_comb begin
        PCWire      = 1'b1;
        IFID_Write  = 1'b1;
        ControlWire = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (RESET) begin
            PCWire = 1'b1;
        end else if (EXMEM_BranchTaken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (DMem_Busy) begin
            // Hold everything; controls pass so no bubble is inserted.
            PCWire      = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if ((state_r == LSTALL) || hz_s) begin
            PCWire      = 1'b0;
            IFID_Write  = 1'b0;
            ControlWire = 1'b0;
        end else begin
            PCWire = 1'b1;
        end
    end

    // Stall sequencer: counts remaining bubbles, held by freeze, aborted by branch.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= RUN;
            rem_r   <= '0;
        end else if (EXMEM_BranchTaken) begin
            state_r <= RUN;
            rem_r   <= '0;
        end else if (DMem_Busy) begin
            state_r <= state_r;
            rem_r   <= rem_r;
        end else begin
            case (state_r)
                RUN: begin
                    // With a single bubble the next ID/EX holds it, so hz clears itself.
                    if (hz_s && (LOAD_STALL_CYCLES > 1)) begin
                        state_r <= LSTALL;
                        rem_r   <= REM_INIT;
                    end else begin
                        state_r <= RUN;
                        rem_r   <= '0;
                    end
                end
                LSTALL: begin
                    if (rem_r <= REM_W'(1)) begin
                        state_r <= RUN;
                        rem_r   <= '0;
                    end else begin
                        state_r <= LSTALL;
                        rem_r   <= rem_r - REM_W'(1);
                    end
                end
                default: begin
                    state_r <= RUN;
                    rem_r   <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held (stall or freeze).
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_count_r <= '0;
        end else if (!PCWire && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + PERF_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign StallCount = stall_count_r;

endmodule
